// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cube_pkg
//  Description : Shared constants for the cube-state store path: cube
//                geometry, store FSM state encoding and the layout of the
//                valid/sequence word polled by the processor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cube_pkg;

    // Cube geometry
    localparam int NUM_SQ    = 24;
    localparam int COLOR_W   = 3;
    localparam int VALID_OFS = 24;

    // Store FSM state encoding
    localparam int            STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_INVAL = 3'd1;
    localparam logic [STATE_W-1:0] S_SQ    = 3'd2;
    localparam logic [STATE_W-1:0] S_VALID = 3'd3;
    localparam logic [STATE_W-1:0] S_HOLD  = 3'd4;

    // Valid word: bit 0 = cube valid, bits [8:1] = snapshot sequence number
    localparam int VALID_WORD_W  = 32;
    localparam int VALID_FLAG_BIT = 0;
    localparam int VALID_SEQ_LSB  = 1;
    localparam int VALID_SEQ_W    = 8;

    function automatic logic [VALID_WORD_W-1:0] valid_word(input logic [VALID_SEQ_W-1:0] seq);
        logic [VALID_WORD_W-1:0] w;
        w                                 = '0;
        w[VALID_FLAG_BIT]                 = 1'b1;
        w[VALID_SEQ_LSB +: VALID_SEQ_W]   = seq;
        return w;
    endfunction

endpackage : cube_pkg
`default_nettype wire

// File: rtl/switch_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : switch_sync_edge
//  Description : Two-flop synchroniser for an asynchronous level input,
//                followed by a rising-edge detector.
//  Ports       : clk     - sampling clock
//                rst     - synchronous active-high reset
//                i_async - raw asynchronous level (switch / button)
//                o_level - synchronised level
//                o_rise  - one-cycle pulse on a synchronised 0->1 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  = r_sync2 & ~r_prev;

endmodule : switch_sync_edge
`default_nettype wire

// File: rtl/cube_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cube_store_ctrl
//  Description : On a rising edge of the store switch, freezes the 24 square
//                colours and writes them to dmem as an ordered burst:
//                invalidate valid word, squares 1..24, then valid word with
//                an incremented sequence number.
//  Ports       : vga_clk      - VGA pixel clock
//                reset        - synchronous active-high reset
//                store_switch - raw asynchronous store switch
//                squares      - packed colours, sq_1 in [2:0]
//                dmem_gnt     - arbiter grant (commit = dmem_req & dmem_gnt)
//                dmem_req/we  - write request / enable (identical)
//                dmem_addr    - write word address
//                dmem_data    - write data
//                busy         - snapshot in progress
//                done         - one-cycle pulse after the final write
//                seq_count    - completed snapshots, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module cube_store_ctrl
    import cube_pkg::*;
#(
    parameter int               NUM_SQ    = cube_pkg::NUM_SQ,
    parameter int               COLOR_W   = cube_pkg::COLOR_W,
    parameter int               ADDR_W    = 12,
    parameter int               DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'd1,
    parameter int               VALID_OFS = cube_pkg::VALID_OFS
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic                      store_switch,
    input  logic [NUM_SQ*COLOR_W-1:0] squares,
    input  logic                      dmem_gnt,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_data,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                seq_count
);

    localparam int                IDX_W        = $clog2(NUM_SQ);
    localparam logic [ADDR_W-1:0] c_valid_addr = BASE_ADDR + ADDR_W'(VALID_OFS);
    localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(NUM_SQ - 1);

    logic w_sw_level;
    logic w_sw_rise;

    switch_sync_edge u_store_sync (
        .clk     (vga_clk),
        .rst     (reset),
        .i_async (store_switch),
        .o_level (w_sw_level),
        .o_rise  (w_sw_rise)
    );

    logic [STATE_W-1:0]        r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_idx, w_idx_nxt;
    logic [NUM_SQ*COLOR_W-1:0] r_shadow;
    logic                      r_req, w_req_nxt;
    logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
    logic [DATA_W-1:0]         r_data, w_data_nxt;
    logic                      r_done, w_done_nxt;
    logic [7:0]                r_seq;
    logic [COLOR_W-1:0]        w_sq_sel;
    logic                      w_commit;

    assign w_commit = r_req & dmem_gnt;

    // State and registered outputs
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_seq    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            if (w_done_nxt) begin
                r_seq <= r_seq + 8'd1;
            end
            // Snapshot is taken only when a burst is launched, then frozen
            if (r_state == S_IDLE && w_sw_rise) begin
                r_shadow <= squares;
            end
        end
    end

    // Next-state logic: every burst state advances only on a commit
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE:  if (w_sw_rise) w_state_nxt = S_INVAL;
            S_INVAL: if (w_commit) begin
                         w_state_nxt = S_SQ;
                         w_idx_nxt   = '0;
                     end
            S_SQ:    if (w_commit) begin
                         if (r_idx == c_last_idx) w_state_nxt = S_VALID;
                         else                     w_idx_nxt   = r_idx + 1'b1;
                     end
            S_VALID: if (w_commit) w_state_nxt = S_HOLD;
            S_HOLD:  if (!w_sw_level) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values for the next cycle, decoded from the next state so
    // that address/data are registered and only move after a commit.
    assign w_sq_sel = r_shadow[w_idx_nxt*COLOR_W +: COLOR_W];

    always_comb begin
        w_req_nxt  = 1'b0;
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        w_done_nxt = (r_state == S_VALID) && w_commit;
        case (w_state_nxt)
            S_INVAL: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = c_valid_addr;
                w_data_nxt = '0;
            end
            S_SQ: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = BASE_ADDR + ADDR_W'(w_idx_nxt);
                w_data_nxt = DATA_W'(w_sq_sel);
            end
            S_VALID: begin
                w_req_nxt  = 1'b1;
                w_addr_nxt = c_valid_addr;
                w_data_nxt = DATA_W'(valid_word(r_seq + 8'd1));
            end
            default: ;
        endcase
    end

    assign dmem_req  = r_req;
    assign dmem_we   = r_req;
    assign dmem_addr = r_addr;
    assign dmem_data = r_data;
    assign busy      = r_req;
    assign done      = r_done;
    assign seq_count = r_seq;

endmodule : cube_store_ctrl
`default_nettype wire
